// File: rtl/regfile_write_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_bank_pkg
// Brief   : Shared register-file constants and reg_bus slice helper.
// Revision: 1.0
// ============================================================================
package regfile_write_bank_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [REG_WIDTH-1:0]  reg_word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Bit offset of register idx within reg_bus; mux_32 wiring uses the same rule.
  function automatic int reg_offset(input int idx);
    return REG_WIDTH * idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_bank_if
// Brief   : Write request, completion handshake and flat register bus.
// Revision: 1.0
// ============================================================================
interface regfile_write_bank_if;
  import regfile_write_bank_pkg::*;

  logic                           ctrl_writeEnable;
  logic [REG_ADDR_W-1:0]          ctrl_writeReg;
  logic [REG_WIDTH-1:0]           data_writeReg;
  logic [REG_WIDTH*REG_COUNT-1:0] reg_bus;
  logic                           wr_done;
  logic [REG_ADDR_W-1:0]          wr_done_reg;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  reg_bus, wr_done, wr_done_reg
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output reg_bus, wr_done, wr_done_reg
  );

endinterface
`default_nettype wire

// File: rtl/regfile_write_bank_decoder_5to32.sv
`default_nettype none
// ============================================================================
// Module  : decoder_5to32
// Brief   : Enable-gated 5-to-32 one-hot write select.
// Revision: 1.0
// ============================================================================
module decoder_5to32
  import regfile_write_bank_pkg::*;
(
  input  logic [4:0]  addr,
  input  logic        enable,
  output logic [31:0] onehot
);

  always_comb begin
    onehot = '0;
    if (enable) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_bank.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_bank
// Brief   : Write side of the 32x32 register file; register 0 reads as zero.
// Revision: 1.0
// ============================================================================
module regfile_write_bank
  import regfile_write_bank_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int DEPTH  = REG_COUNT,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  regfile_write_bank_if.slave   bus
);

  logic [DEPTH-1:0]  w_sel;
  logic              r_wr_done;
  logic [ADDR_W-1:0] r_wr_done_reg;

  decoder_5to32 u_decoder (
    .addr   (bus.ctrl_writeReg),
    .enable (bus.ctrl_writeEnable),
    .onehot (w_sel)
  );

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_regs
      if (i == ZERO_REG) begin : g_zero
        assign bus.reg_bus[reg_offset(i) +: WIDTH] = '0;
      end else begin : g_storage
        logic [WIDTH-1:0] r_q;

        always_ff @(posedge clock or negedge ctrl_reset_n) begin
          if (!ctrl_reset_n) begin
            r_q <= '0;
          end else if (w_sel[i]) begin
            r_q <= bus.data_writeReg;
          end
        end

        assign bus.reg_bus[reg_offset(i) +: WIDTH] = r_q;
      end
    end
  endgenerate

  // Index-0 writes still complete the handshake even though no data is stored.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_wr_done     <= 1'b0;
      r_wr_done_reg <= '0;
    end else begin
      r_wr_done <= bus.ctrl_writeEnable;
      if (bus.ctrl_writeEnable) begin
        r_wr_done_reg <= bus.ctrl_writeReg;
      end
    end
  end

  assign bus.wr_done     = r_wr_done;
  assign bus.wr_done_reg = r_wr_done_reg;

endmodule
`default_nettype wire

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the 32-entry x 32-bit register file.
- The existing 32:1 read mux (mux_32) selects one register onto a read port. This block is the other end of that path.
- It decodes a 5-bit write address, latches write data into the selected register on the clock edge, and exposes all 32 register values as a flat bus that feeds the read muxes.
- Register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; fixed at 32 because the address is 5 bits.
- ADDR_W, 5, write address width; must equal log2(DEPTH).

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- ctrl_reset_n  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- ctrl_writeEnable  input  1  write request, sampled on the rising edge of clock.
- ctrl_writeReg  input  ADDR_W  destination register index.
- data_writeReg  input  WIDTH  data to be written.
- reg_bus  output  WIDTH*DEPTH  flat register contents; register i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- wr_done  output  1  one-cycle pulse, asserted in the cycle after a committed write.
- wr_done_reg  output  ADDR_W  index of the register written, valid while wr_done=1.

Behaviour:
- Reset (ctrl_reset_n=0, asynchronous):
  - All registers go to 0.
  - wr_done=0 and wr_done_reg=0.
  - Reset asserted mid-write, including in the same cycle as a write edge, wins: no write takes effect.
  - Deassertion is synchronised externally; the first write is accepted on the first rising edge with ctrl_reset_n=1.
- Decode:
  - A 5-to-32 one-hot decoder is gated by ctrl_writeEnable: sel[i] = ctrl_writeEnable && (ctrl_writeReg == i).
  - At most one sel bit is high at any time.
- Write, latency 1:
  - On a rising edge with sel[i]=1 and i != 0, register i <= data_writeReg.
  - The new value is visible on reg_bus after that edge.
  - There is no combinational write-through: in the write cycle itself, reg_bus shows the old value.
- Register 0:
  - Always reads 0. Writes to index 0 are discarded.
  - wr_done still pulses for an index-0 write, with wr_done_reg=0, so the handshake stays uniform.
- wr_done:
  - Registered. Equals the value of ctrl_writeEnable sampled at the previous edge.
  - wr_done_reg equals the sampled ctrl_writeReg.
  - While wr_done=0, wr_done_reg holds its last value.
- Back-to-back writes:
  - A write is accepted every cycle with no stall.
  - Consecutive writes to the same register: the last one wins.
  - wr_done stays high continuously across the sequence.
- Non-selected registers hold their value.
- ctrl_writeEnable=0: no register changes, regardless of ctrl_writeReg or data_writeReg, including X/garbage values.
- There are no illegal addresses: all 5-bit values are valid.

Decomposition:
- Shared package/header holds:
  - REG_WIDTH=32, REG_COUNT=32, REG_ADDR_W=5, ZERO_REG=0.
  - A macro or function giving the reg_bus slice offset for index i, also used by mux_32 wiring.
- Sub-module decoder_5to32:
  - Combinational; inputs addr[4:0] and enable; output one-hot [31:0].
  - Instantiated once.
- The 32 register instances are generated in a loop; index 0 is tied to zero.
- Target size: about 150 lines of RTL including the decoder.

Test Plan:
- Reset/idle:
  - Stimulus: assert ctrl_reset_n=0 for 2 cycles, release, then wait 1 cycle with ctrl_writeEnable=0.
  - Required: reg_bus is all zeros; wr_done=0.
- Single write:
  - Stimulus: one cycle with ctrl_writeEnable=1, ctrl_writeReg=17, data_writeReg=32'd17.
  - Required: after the edge, reg slice 17 = 17 and every other slice = 0; next cycle wr_done=1 with wr_done_reg=17.
- Register 0 protection:
  - Stimulus: write 32'hDEADBEEF to index 0.
  - Required: slice 0 stays 0; wr_done pulses with wr_done_reg=0.
- Back-to-back writes:
  - Stimulus, on consecutive edges: (23, 32'd23), (7, 32'd7), (23, 32'hFFFF_FFFF).
  - Required: finally slice 23 = FFFFFFFF and slice 7 = 7; wr_done is high for 3 consecutive cycles.
- Enable gating:
  - Stimulus: ctrl_writeEnable=0 with ctrl_writeReg=5 and data_writeReg=32'h1234 held for 3 cycles.
  - Required: slice 5 unchanged (0); wr_done=0.
- Asynchronous reset mid-stream:
  - Stimulus: after writes to 17 and 23, assert ctrl_reset_n low between clock edges.
  - Required: reg_bus is zero before the next edge; wr_done drops to 0 immediately.
- Integration check:
  - Stimulus: drive reg_bus into a mux_32 with sel=5'b10001 after the single-write scenario.
  - Required: mux output = 32'd17.
